// File: rtl/vga_timing_pkg.sv
// Shared raster-timing definitions: stock video modes, phase-boundary helpers
// and the generator state type.
package vga_timing_pkg;

   typedef enum logic {IDLE, RUN} vgaState_t;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;

   // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FP     = 40;
   localparam int SVGA800_H_SYNC   = 128;
   localparam int SVGA800_H_BP     = 88;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FP     = 1;
   localparam int SVGA800_V_SYNC   = 4;
   localparam int SVGA800_V_BP     = 23;

   function automatic int axisTotal(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int syncStart(input int active, input int fp);
      return active + fp;
   endfunction

   function automatic int syncEnd(input int active, input int fp, input int sync);
      return active + fp + sync;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with active / sync / wrap decodes against
// precomputed boundaries.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int W      = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         active,
   output logic         sync_raw,
   output logic         wrap
);

   localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_BEG = W'(syncStart(ACTIVE, FP));
   localparam logic [W-1:0] SYNC_END = W'(syncEnd(ACTIVE, FP, SYNC));
   localparam logic [W-1:0] LAST     = W'(axisTotal(ACTIVE, FP, SYNC, BP) - 1);
   // When a phase runs to the end of the axis its upper bound may equal 2^W,
   // which would alias to 0; those bounds are treated as always satisfied.
   localparam bit ACT_TO_END  = (FP + SYNC + BP == 0);
   localparam bit SYNC_TO_END = (BP == 0);

   assign active   = ACT_TO_END || (cnt < ACT_END);
   assign sync_raw = (cnt >= SYNC_BEG) && (SYNC_TO_END || (cnt < SYNC_END));
   assign wrap     = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= wrap ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable raster timing engine: sync, data-enable, active coordinates and
// frame/line markers, all registered and advanced on pixel clock-enables.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = VGA640_H_ACTIVE,
   parameter int   H_FP     = VGA640_H_FP,
   parameter int   H_SYNC   = VGA640_H_SYNC,
   parameter int   H_BP     = VGA640_H_BP,
   parameter int   V_ACTIVE = VGA640_V_ACTIVE,
   parameter int   V_FP     = VGA640_V_FP,
   parameter int   V_SYNC   = VGA640_V_SYNC,
   parameter int   V_BP     = VGA640_V_BP,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0,
   parameter int   CNT_W    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_ce,
   input  logic             en,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic             frame_start,
   output logic             line_start
);

   vgaState_t        state;
   logic             go, clr, vInc;
   logic [CNT_W-1:0] hCnt, vCnt;
   logic             hAct, vAct, hSyncRaw, vSyncRaw, hWrap, vWrap;
   // Track "counters sit at line/frame origin" as flags so the markers need
   // no zero compares on the counters.
   logic             lineHead, frameHead;

   assign go   = en && pix_ce;
   // Counters are already parked at 0 in IDLE; only a running stop clears them.
   assign clr  = (state == RUN) && !en;
   assign vInc = hWrap && go;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(CNT_W)
   ) uHAxis (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(go),
      .cnt(hCnt), .active(hAct), .sync_raw(hSyncRaw), .wrap(hWrap)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(CNT_W)
   ) uVAxis (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(vInc),
      .cnt(vCnt), .active(vAct), .sync_raw(vSyncRaw), .wrap(vWrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         de          <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         lineHead    <= 1'b1;
         frameHead   <= 1'b1;
      end else if (!en) begin
         state       <= IDLE;
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         de          <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         lineHead    <= 1'b1;
         frameHead   <= 1'b1;
      end else if (pix_ce) begin
         // The start cycle itself emits pixel (0,0).
         state       <= RUN;
         hsync       <= hSyncRaw ? H_POL : ~H_POL;
         vsync       <= vSyncRaw ? V_POL : ~V_POL;
         de          <= hAct && vAct;
         pix_x       <= (hAct && vAct) ? hCnt : '0;
         pix_y       <= (hAct && vAct) ? vCnt : '0;
         frame_start <= frameHead;
         line_start  <= lineHead && vAct;
         lineHead    <= hWrap;
         frameHead   <= hWrap && vWrap;
      end
   end

endmodule
